// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA sequencer.
// State encoding, address-control codes and step-code selection.
package dma_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_RD     = 4'd2,
        S_MOD    = 4'd3,
        S_WR     = 4'd4,
        S_XSTEP  = 4'd5,
        S_YSTEP  = 4'd6,
        S_PGSTEP = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam logic [2:0] AD_HOLD   = 3'd0;
    localparam logic [2:0] AD_XINC   = 3'd1;
    localparam logic [2:0] AD_YINC   = 3'd2;
    localparam logic [2:0] AD_LDBASE = 3'd3;
    localparam logic [2:0] AD_PGINC  = 3'd4;
    localparam logic [2:0] AD_XSKIP  = 3'd5;
    localparam logic [2:0] AD_YSKIP  = 3'd6;

    function automatic logic [2:0] step_code(
        input logic       skip,
        input logic [2:0] skip_code,
        input logic [2:0] inc_code
    );
        return skip ? skip_code : inc_code;
    endfunction

endpackage

// File: rtl/dma_seq_cnt.sv
// Loadable down-counter with an is-one flag.
// Load wins over decrement; wraps modulo 2^CNT_W.
module dma_seq_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_one
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_is_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/dma_seq_ctrl.sv
// DMA sequencer: load, read/modify/write and x/y/page step phases.
// Moore outputs toward the memory port and the address generator.
module dma_seq_ctrl
    import dma_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_xlen,
    input  logic [CNT_W-1:0] i_ylen,
    input  logic             i_rmwb,
    input  logic             i_xskip,
    input  logic             i_yskip,
    input  logic             i_page,
    input  logic             i_abort,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [2:0]       o_adctlp_b,
    output logic [3:0]       o_dmpst,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    state_t           w_next;
    state_t           w_access;
    logic [CNT_W-1:0] r_xlen;
    logic             r_rmwb;
    logic             r_xskip;
    logic             r_yskip;
    logic             w_latch;
    logic             w_x_load;
    logic             w_x_dec;
    logic             w_y_load;
    logic             w_y_dec;
    logic             w_x_one;
    logic             w_y_one;
    logic [CNT_W-1:0] w_x_val;
    logic [2:0]       w_code;

    assign w_access = r_rmwb ? S_WR : S_RD;
    // Row reload during YSTEP uses the latched length, not the live input.
    assign w_x_val  = w_latch ? i_xlen : r_xlen;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_xlen  <= '0;
            r_rmwb  <= 1'b0;
            r_xskip <= 1'b0;
            r_yskip <= 1'b0;
        end else if (w_latch) begin
            r_xlen  <= i_xlen;
            r_rmwb  <= i_rmwb;
            r_xskip <= i_xskip;
            r_yskip <= i_yskip;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_x_load = 1'b0;
        w_x_dec  = 1'b0;
        w_y_load = 1'b0;
        w_y_dec  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_latch  = 1'b1;
                    w_x_load = 1'b1;
                    w_y_load = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD:   w_next = w_access;
            S_RD: begin
                if (i_mem_ack) begin
                    w_next = S_MOD;
                end
            end
            S_MOD:    w_next = S_WR;
            S_WR: begin
                if (i_mem_ack) begin
                    w_next = S_XSTEP;
                end
            end
            S_XSTEP: begin
                if (w_x_one) begin
                    w_next = S_YSTEP;
                end else begin
                    w_x_dec = 1'b1;
                    w_next  = i_page ? S_PGSTEP : w_access;
                end
            end
            S_YSTEP: begin
                w_x_load = 1'b1;
                if (w_y_one) begin
                    w_next = S_DONE;
                end else begin
                    w_y_dec = 1'b1;
                    w_next  = i_page ? S_PGSTEP : w_access;
                end
            end
            S_PGSTEP: w_next = w_access;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (i_abort && (r_state != S_IDLE)) begin
            w_next   = S_IDLE;
            w_x_load = 1'b0;
            w_x_dec  = 1'b0;
            w_y_dec  = 1'b0;
        end
    end

    dma_seq_cnt #(
        .CNT_W(CNT_W)
    ) u_xcnt (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_x_load),
        .i_load_val(w_x_val),
        .i_dec     (w_x_dec),
        .o_is_one  (w_x_one)
    );

    dma_seq_cnt #(
        .CNT_W(CNT_W)
    ) u_ycnt (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_y_load),
        .i_load_val(i_ylen),
        .i_dec     (w_y_dec),
        .o_is_one  (w_y_one)
    );

    always_comb begin
        w_code = AD_HOLD;
        unique case (r_state)
            S_LOAD:   w_code = AD_LDBASE;
            S_XSTEP:  w_code = step_code(r_xskip, AD_XSKIP, AD_XINC);
            S_YSTEP:  w_code = step_code(r_yskip, AD_YSKIP, AD_YINC);
            S_PGSTEP: w_code = AD_PGINC;
            default:  w_code = AD_HOLD;
        endcase
    end

    assign o_adctlp_b = ~w_code;
    assign o_dmpst    = r_state;
    assign o_mem_req  = (r_state == S_RD) || (r_state == S_WR);
    assign o_mem_we   = (r_state == S_WR);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);

endmodule

// File: doc/dma_seq_ctrl.md
# dma_seq_ctrl

Sequential controller for the DMA address/next-state decode path. It owns the 4-bit DMA state register and the x/y transfer counters, and sequences load, read, modify, write, x-step, y-step and page-step phases. Each phase produces a memory request/ack handshake toward the memory port and a 3-bit active-low address-control code toward the address generator. It sits between the DMA register file (start, lengths, mode flags) and the address unit/memory port.

## Interface
- CNT_W, default 8, width of the x and y length counters; a length of 0 means 2^CNT_W
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a transfer; sampled only in IDLE
- xlen  in  CNT_W  elements per row; latched on accepted start
- ylen  in  CNT_W  rows; latched on accepted start
- rmwb  in  1  0 = read-modify-write mode, 1 = write-only fill; latched on start
- xskip  in  1  x-step uses stride-skip code instead of increment; latched on start
- yskip  in  1  y-step uses stride-skip code instead of increment; latched on start
- page  in  1  address unit reports page crossing; sampled in XSTEP/YSTEP
- abort  in  1  terminate the transfer immediately
- mem_ack  in  1  memory accepted the current request
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- adctlp_b  out  3  address-control code, active low (adctlp_b = ~code)
- dmpst  out  4  current state encoding
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- State encodings: IDLE=0, LOAD=1, RD=2, MOD=3, WR=4, XSTEP=5, YSTEP=6, PGSTEP=7, DONE=8. Codes 9–15 are illegal and go to IDLE on the next edge.
- Address-control codes: HOLD=0, LDBASE=3, XINC=1, XSKIP=5, YINC=2, YSKIP=6, PGINC=4. LOAD drives LDBASE. XSTEP drives XSKIP if the latched xskip=1, else XINC. YSTEP drives YSKIP or YINC the same way. PGSTEP drives PGINC. Every other state drives HOLD.
- IDLE: on start=1, latch the length and mode inputs, set xcnt=xlen and ycnt=ylen, then go to LOAD.
- LOAD goes to RD when rmwb=0, otherwise to WR. This target is the "access state".
- RD: mem_req=1, mem_we=0. Stay in RD until mem_ack=1, then go to MOD.
- MOD: one cycle, then WR.
- WR: mem_req=1, mem_we=1. Stay in WR until mem_ack=1, then go to XSTEP.
- XSTEP:
  - if xcnt==1, go to YSTEP;
  - else decrement xcnt, then go to PGSTEP if page=1, otherwise to the access state.
- YSTEP: reload xcnt=xlen.
  - if ycnt==1, go to DONE;
  - else decrement ycnt, then go to PGSTEP if page=1, otherwise to the access state.
- PGSTEP: one cycle, then the access state.
- DONE: done=1, then go to IDLE.
- Counter arithmetic is modulo 2^CNT_W. A latched length of 0 decrements to all-ones and yields 2^CNT_W iterations.
- abort=1 in any non-IDLE state forces IDLE on the next edge with no done pulse. abort takes priority over a simultaneous mem_ack.
- start while busy=1 is ignored. mem_ack outside RD/WR is ignored.

## Timing
- Moore machine. mem_req, mem_we, adctlp_b, busy and done are decoded from the registered state only, with no input-to-output combinational path.
- Reset values: state IDLE (dmpst=0), xcnt=ycnt=0, latched flags 0, mem_req=0, mem_we=0, adctlp_b=3'b111, busy=0, done=0.
- A reset asserted mid-transfer returns the block to IDLE on that edge. Any outstanding request is dropped.
- Latency: with start high at cycle 0, LOAD is at cycle 1 and the first mem_req is at cycle 2.
- mem_req stays high, with state held, until mem_ack is sampled high. Each access costs at least 1 cycle.

## Structure
- Shared package dma_seq_pkg holds:
  - the state enum (4-bit);
  - the adctl code constants;
  - a CNT_W-independent function for the skip-versus-increment code selection.
- One sub-module, dma_seq_cnt: a CNT_W down-counter with load, decrement and is-one flag. It is instantiated once for x and once for y.

## Test plan
- Reset: apply rst with random inputs -> dmpst=0, adctlp_b=3'b111, mem_req=0, busy=0, done=0.
- Fill: xlen=2, ylen=1, rmwb=1, mem_ack tied 1, start at cycle 0 -> states LOAD@1, WR@2, XSTEP@3, WR@4, XSTEP@5, YSTEP@6, DONE@7; done high only at cycle 7; exactly 2 writes.
- RMW with wait states: xlen=1, ylen=2, rmwb=0, mem_ack delayed 3 cycles per request -> sequence RD, MOD, WR per element; mem_req held 4 cycles per access; 2 reads and 2 writes; YSTEP adctlp_b=~YINC.
- Skip and page: xskip=1, page pulsed in the first XSTEP -> adctlp_b=~XSKIP (3'b010), then PGSTEP with adctlp_b=~PGINC (3'b011) for one cycle, then the access state.
- Abort: abort together with mem_ack in WR -> IDLE next cycle, no done, no further mem_req. A start during busy has no effect.
- Zero length: xlen=0, ylen=1, CNT_W=8 -> exactly 256 writes, then done.
